// File: rtl/registrador_banco.sv
// registrador_banco: register file with 2**ADDR_W registers of DATA_W bits.
// Two combinational read ports and one synchronous write port. Writes become
// visible on the reads right after the write edge. There is no bypass, so a
// read of the register being written shows the old value until that edge.
// Reset is synchronous and active-high.
// Optional build macro ZERO_REG_EN: register 0 reads as zero and ignores
// writes, and no flops are built for it. Without the macro, register 0 is an
// ordinary register.
module registrador_banco #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] registrador1,
    input  logic [ADDR_W-1:0] registrador2,
    input  logic [ADDR_W-1:0] writeRegistrador,
    input  logic [DATA_W-1:0] writeData,
    input  logic              we,
    output logic [DATA_W-1:0] outData1,
    output logic [DATA_W-1:0] outData2
);

    localparam int NUM_REGS = 2 ** ADDR_W;

`ifdef ZERO_REG_EN
    // Register 0 has no storage. Its read view is tied to zero below.
    localparam int FIRST_REG = 1;
`else
    localparam int FIRST_REG = 0;
`endif

    // Physical storage covers only the registers that can actually hold data.
    logic [DATA_W-1:0] regFileR [FIRST_REG:NUM_REGS-1];

    // Full-range read view. Both ports index this array.
    logic [DATA_W-1:0] readViewS [0:NUM_REGS-1];

    genvar g;
    generate
        for (g = 0; g < NUM_REGS; g = g + 1) begin : gen_read_view
            if (g < FIRST_REG) begin : gen_zero
                assign readViewS[g] = {DATA_W{1'b0}};
            end else begin : gen_store
                assign readViewS[g] = regFileR[g];
            end
        end
    endgenerate

    // Reset clears the whole file. Otherwise, an enabled write updates only
    // the addressed register. Reset wins over a write in the same cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = FIRST_REG; i < NUM_REGS; i++) begin
                regFileR[i] <= {DATA_W{1'b0}};
            end
        end else if (we) begin
            for (int i = FIRST_REG; i < NUM_REGS; i++) begin
                if (writeRegistrador == ADDR_W'(i)) begin
                    regFileR[i] <= writeData;
                end else begin
                    regFileR[i] <= regFileR[i];
                end
            end
        end else begin
            for (int i = FIRST_REG; i < NUM_REGS; i++) begin
                regFileR[i] <= regFileR[i];
            end
        end
    end

    // Read ports are combinational with zero-cycle latency from the address.
    always_comb begin
        outData1 = readViewS[registrador1];
        outData2 = readViewS[registrador2];
    end

endmodule

// File: tb/tb_registrador_banco.sv
// Self-checking bench for registrador_banco. A reference model of the register
// file is updated at each clock edge. The expected read values are queued
// from that model when the read addresses are driven. They are then popped
// and compared against the DUT outputs. Define ZERO_REG_EN for both the bench
// and the RTL to check the hardwired-zero build.
module tb_registrador_banco;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NUM_REGS = 32;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] registrador1;
    logic [ADDR_W-1:0] registrador2;
    logic [ADDR_W-1:0] writeRegistrador;
    logic [DATA_W-1:0] writeData;
    logic              we;
    logic [DATA_W-1:0] outData1;
    logic [DATA_W-1:0] outData2;

    logic [DATA_W-1:0] model [NUM_REGS];
    logic [DATA_W-1:0] expQ [$];
    int checks = 0;
    int errors = 0;

    registrador_banco #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk),
        .rst(rst),
        .registrador1(registrador1),
        .registrador2(registrador2),
        .writeRegistrador(writeRegistrador),
        .writeData(writeData),
        .we(we),
        .outData1(outData1),
        .outData2(outData2)
    );

    // Free-running clock with a 10-unit period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The run time is bounded so that a stalled simulation still ends.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic checkValue(input string tag, input logic [DATA_W-1:0] observed,
                              input logic [DATA_W-1:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Queue the expectations for the current read addresses.
    // Let the logic settle, then pop the expectations and compare.
    task automatic sampleReads(input string tag);
        logic [DATA_W-1:0] e1;
        logic [DATA_W-1:0] e2;
        expQ.push_back(model[registrador1]);
        expQ.push_back(model[registrador2]);
        #1;
        e1 = expQ.pop_front();
        e2 = expQ.pop_front();
        checkValue({tag, "_p1"}, outData1, e1);
        checkValue({tag, "_p2"}, outData2, e2);
    endtask

    // Advance one rising edge and apply the same update to the model.
    task automatic clockEdge();
        @(posedge clk);
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
        end else if (we) begin
`ifdef ZERO_REG_EN
            if (writeRegistrador != 5'd0) model[writeRegistrador] = writeData;
`else
            model[writeRegistrador] = writeData;
`endif
        end
        #1;
    endtask

    initial begin
        for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
        rst = 1'b1;
        we = 1'b0;
        registrador1 = 5'd0;
        registrador2 = 5'd0;
        writeRegistrador = 5'd0;
        writeData = 32'd0;
        #2;

        // Reset, then read while idle.
        clockEdge();
        rst = 1'b0;
        registrador1 = 5'd1;
        registrador2 = 5'd4;
        sampleReads("reset_idle");
        for (int i = 0; i < NUM_REGS; i += 4) begin
            registrador1 = 5'(i);
            registrador2 = 5'(31 - i);
            sampleReads("reset_all");
        end

        // A write with we low changes nothing.
        we = 1'b0;
        writeRegistrador = 5'd0;
        writeData = 32'd2;
        clockEdge();
        registrador1 = 5'd0;
        registrador2 = 5'd0;
        sampleReads("we_off");

        // Write register 0. The old value shows before the edge.
        we = 1'b1;
        sampleReads("w0_pre");
        clockEdge();
        sampleReads("w0_post");

        // Write register 4, then check that it holds its value.
        writeRegistrador = 5'd4;
        writeData = 32'hDEADBEEF;
        clockEdge();
        we = 1'b0;
        writeData = 32'd0;
        registrador1 = 5'd0;
        registrador2 = 5'd4;
        for (int k = 0; k < 3; k++) begin
            clockEdge();
            sampleReads("retain");
        end

        // Dual read of the register being written, with no bypass.
        we = 1'b1;
        writeRegistrador = 5'd7;
        writeData = 32'd5;
        clockEdge();
        writeData = 32'd9;
        registrador1 = 5'd7;
        registrador2 = 5'd7;
        sampleReads("nobyp_pre");
        clockEdge();
        sampleReads("nobyp_post");

        // Top address boundary.
        writeRegistrador = 5'd31;
        writeData = 32'hA5A5_0031;
        registrador1 = 5'd31;
        registrador2 = 5'd30;
        clockEdge();
        sampleReads("top_addr");

        // Reset takes priority over a write in the same cycle.
        writeRegistrador = 5'd3;
        writeData = 32'd77;
        clockEdge();
        rst = 1'b1;
        writeData = 32'd11;
        clockEdge();
        rst = 1'b0;
        we = 1'b0;
        registrador1 = 5'd3;
        registrador2 = 5'd4;
        sampleReads("rst_prio");

        // Random traffic. Read back the write target before and after each edge.
        for (int n = 0; n < 80; n++) begin
            we = 1'($urandom_range(0, 1));
            writeRegistrador = 5'($urandom);
            writeData = $urandom;
            registrador1 = writeRegistrador;
            registrador2 = 5'($urandom);
            sampleReads("rnd_pre");
            clockEdge();
            sampleReads("rnd_post");
        end

        // Final sweep of the whole file.
        we = 1'b0;
        for (int i = 0; i < NUM_REGS; i++) begin
            registrador1 = 5'(i);
            registrador2 = 5'(NUM_REGS - 1 - i);
            sampleReads("sweep");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
